ldpc_cw_serializer: RTL
=======================

LDPC_CW_SERIALIZER -- requirements
Module: ldpc_cw_serializer

Interface
REQ-001 The block SHALL have parameter LDPC_WORD_LENGTH, default 648, meaning codeword width in bits.
REQ-002 The block SHALL have parameter Z, default 27, meaning lifting size and output chunk width.
REQ-003 The block SHALL have parameter NUM_CHUNKS, default 24, meaning LDPC_WORD_LENGTH/Z; a mismatch SHALL be an elaboration error.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 cw_load  input  1  one-cycle pulse: codeword is valid this cycle.
REQ-007 codeword  input  LDPC_WORD_LENGTH  encoder output word, {info, parity}.
REQ-008 cw_drop  output  1  one-cycle pulse: cw_load arrived while both buffers were full.
REQ-009 m_data  output  Z  current output chunk.
REQ-010 m_valid  output  1  m_data holds a valid chunk.
REQ-011 m_ready  input  1  downstream accepts the chunk when m_valid and m_ready are both high.
REQ-012 m_first  output  1  high with chunk 0 of a codeword.
REQ-013 m_last  output  1  high with chunk NUM_CHUNKS-1 of a codeword.
REQ-014 busy  output  1  at least one buffer is occupied.

Function
REQ-015 Storage SHALL be two codeword buffers (ping-pong), written and read in alternating order.
REQ-016 On cw_load with a free buffer, codeword SHALL be captured into the write buffer, and the write pointer SHALL toggle.
REQ-017 On cw_load with both buffers full, the word SHALL be discarded, cw_drop SHALL pulse next cycle, and the buffer contents SHALL not change.
REQ-018 If cw_load coincides with the final handshake of a full buffer, the freed slot SHALL accept the load, and cw_drop SHALL stay low.
REQ-019 The FSM SHALL have two states: IDLE (m_valid=0) and SEND (m_valid=1).
REQ-020 IDLE -> SEND SHALL occur when the read buffer is occupied, so the first m_valid rises exactly 1 cycle after the capturing cw_load.
REQ-021 In SEND, chunk index k SHALL drive m_data = buffer[LDPC_WORD_LENGTH-1-k*Z -: Z] (MSB-first, chunk 0 = codeword[647:621]).
REQ-022 k SHALL advance only on handshake, and m_data/m_first/m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-023 On the handshake at k=NUM_CHUNKS-1, the buffer SHALL be freed, k SHALL wrap to 0, and the read pointer SHALL toggle. If the other buffer is occupied, the FSM SHALL remain in SEND with no bubble; otherwise it SHALL go to IDLE.
REQ-024 With m_ready tied high, throughput SHALL be one codeword per NUM_CHUNKS cycles, back-to-back.
REQ-025 m_first SHALL equal (k==0) and m_last SHALL equal (k==NUM_CHUNKS-1), each gated by m_valid.
REQ-026 busy SHALL be high whenever either buffer's occupied flag is set.

Reset
REQ-027 While rst=0 at a clock edge, the following SHALL clear: both occupied flags, both pointers, k, FSM=IDLE, m_valid=0, m_first=0, m_last=0, cw_drop=0, busy=0.
REQ-028 m_data SHALL reset to 0; buffer data need not reset.
REQ-029 Reset asserted mid-codeword SHALL abandon the remaining chunks with no further m_valid. cw_load during reset SHALL be ignored.

Configuration
REQ-030 With macro LDPC_CW_DROP_CNT_EN defined, there SHALL be an extra output drop_cnt[15:0] that increments on each cw_drop, saturates at 16'hFFFF, and clears on reset.
REQ-031 Without LDPC_CW_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Single word, m_ready=1: cw_load at cycle 0 -> m_valid cycles 1..24, m_first at cycle 1, m_last at cycle 24, chunks match codeword MSB-first.
REQ-033 Backpressure: m_ready low for 5 cycles at k=3 -> m_data held at chunk 3, 24 chunks delivered in total, none lost or duplicated.
REQ-034 Two loads 2 cycles apart, m_ready=1 -> 48 contiguous valid cycles, second m_first at cycle 25.
REQ-035 Three loads 1 cycle apart, m_ready=0 -> third load dropped, cw_drop pulses once (drop_cnt=1 when enabled), first two words output intact.
REQ-036 Reset asserted at k=10 -> m_valid=0 and busy=0 next cycle; a following load restarts cleanly at chunk 0.
REQ-037 Load coincident with the final handshake while both buffers are full -> word accepted, cw_drop=0.

Source files
------------

// File: rtl/ldpc_cw_serializer_if.sv
// Codeword load / chunk stream bundle for ldpc_cw_serializer.
// drop_cnt exists only when LDPC_CW_DROP_CNT_EN is defined.
interface ldpc_cw_serializer_if #(
  parameter int unsigned LDPC_WORD_LENGTH = 648,
  parameter int unsigned Z                = 27
);
  logic                        cw_load;
  logic [LDPC_WORD_LENGTH-1:0] codeword;
  logic                        cw_drop;
  logic [Z-1:0]                m_data;
  logic                        m_valid;
  logic                        m_ready;
  logic                        m_first;
  logic                        m_last;
  logic                        busy;
`ifdef LDPC_CW_DROP_CNT_EN
  logic [15:0]                 drop_cnt;

  modport master (
    input  cw_load, codeword, m_ready,
    output cw_drop, m_data, m_valid, m_first, m_last, busy, drop_cnt
  );

  modport slave (
    output cw_load, codeword, m_ready,
    input  cw_drop, m_data, m_valid, m_first, m_last, busy, drop_cnt
  );
`else
  modport master (
    input  cw_load, codeword, m_ready,
    output cw_drop, m_data, m_valid, m_first, m_last, busy
  );

  modport slave (
    output cw_load, codeword, m_ready,
    input  cw_drop, m_data, m_valid, m_first, m_last, busy
  );
`endif
endinterface

// File: rtl/ldpc_cw_serializer.sv
// Ping-pong buffered serializer: LDPC codeword in, Z-bit chunks out MSB-first.
// Define LDPC_CW_DROP_CNT_EN to add the saturating drop_cnt output.
module ldpc_cw_serializer #(
  parameter int unsigned LDPC_WORD_LENGTH = 648,
  parameter int unsigned Z                = 27,
  parameter int unsigned NUM_CHUNKS       = 24
) (
  input logic                  clk,
  input logic                  rst,
  ldpc_cw_serializer_if.master bus
);

  localparam int unsigned KW    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [KW-1:0] KLast = KW'(NUM_CHUNKS - 1);

  if (NUM_CHUNKS * Z != LDPC_WORD_LENGTH) begin : g_bad_params
    $error("ldpc_cw_serializer: NUM_CHUNKS * Z must equal LDPC_WORD_LENGTH");
  end

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  function automatic logic [Z-1:0] chunk(input logic [LDPC_WORD_LENGTH-1:0] w,
                                         input logic [KW-1:0]               idx);
    logic [LDPC_WORD_LENGTH-1:0] sh;
    sh = w >> ((NUM_CHUNKS - 1 - int'(idx)) * Z);
    return sh[Z-1:0];
  endfunction

  logic [LDPC_WORD_LENGTH-1:0] cw_buf_q [2];
  logic [1:0]                  occ_q, occ_d;
  logic                        wr_ptr_q, rd_ptr_q;
  logic [KW-1:0]               k_q;
  state_e                      state_q;
  logic                        m_valid_q, m_first_q, m_last_q, cw_drop_q;
  logic [Z-1:0]                m_data_q;

  logic                        hs, final_hs, load_ok;
  logic [LDPC_WORD_LENGTH-1:0] rd_word, next_word;

  assign hs       = m_valid_q & bus.m_ready;
  assign final_hs = hs & (k_q == KLast);
  // When both slots are full, wr_ptr == rd_ptr, so the slot freed by the last handshake is wr.
  assign load_ok  = bus.cw_load & (~occ_q[wr_ptr_q] | (final_hs & (wr_ptr_q == rd_ptr_q)));
  assign rd_word  = cw_buf_q[rd_ptr_q];
  // Follow-on word: already buffered, or arriving this cycle into the empty slot (no bubble).
  assign next_word = occ_q[~rd_ptr_q] ? cw_buf_q[~rd_ptr_q] : bus.codeword;

  always_comb begin
    occ_d = occ_q;
    if (final_hs) occ_d[rd_ptr_q] = 1'b0;
    if (load_ok)  occ_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst && load_ok) cw_buf_q[wr_ptr_q] <= bus.codeword;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      occ_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      cw_drop_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      cw_drop_q <= bus.cw_load & ~load_ok;
      if (load_ok) wr_ptr_q <= ~wr_ptr_q;

      unique case (state_q)
        StIdle: begin
          if (occ_q[rd_ptr_q] | load_ok) begin
            state_q   <= StSend;
            m_valid_q <= 1'b1;
            k_q       <= '0;
            m_first_q <= 1'b1;
            m_last_q  <= (NUM_CHUNKS == 1);
            m_data_q  <= chunk(occ_q[rd_ptr_q] ? rd_word : bus.codeword, '0);
          end
        end
        StSend: begin
          if (final_hs) begin
            rd_ptr_q <= ~rd_ptr_q;
            k_q      <= '0;
            if (occ_d[~rd_ptr_q]) begin
              m_first_q <= 1'b1;
              m_last_q  <= (NUM_CHUNKS == 1);
              m_data_q  <= chunk(next_word, '0);
            end else begin
              state_q   <= StIdle;
              m_valid_q <= 1'b0;
              m_first_q <= 1'b0;
              m_last_q  <= 1'b0;
            end
          end else if (hs) begin
            k_q       <= k_q + 1'b1;
            m_first_q <= 1'b0;
            m_last_q  <= ((k_q + 1'b1) == KLast);
            m_data_q  <= chunk(rd_word, k_q + 1'b1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.m_data  = m_data_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_first = m_first_q;
  assign bus.m_last  = m_last_q;
  assign bus.cw_drop = cw_drop_q;
  assign bus.busy    = |occ_q;

`ifdef LDPC_CW_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else if (cw_drop_q && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule
